parallel2serial_multi: RTL and testbench
========================================

# parallel2serial_multi

Multi-channel, double-buffered parallel-to-serial converter driving chains of external shift registers (74HC595-style) from the main clock domain. It shifts CHANNELS words of DATA_BITS bits simultaneously on independent data lines that share one serial clock, clear and latch. It accepts the next frame through a valid/ready handshake while the current one shifts, so back-to-back frames run without gaps. It sits between display/LED controllers and the board-level serial I/O pins, and succeeds the single-channel converter.

## Interface
- P_CLK_FREQ, 100: main clock frequency, MHz
- S_CLK_FREQ, 20: maximum serial clock frequency, MHz
- DATA_BITS, 32: bits per channel per frame, ≥1
- CHANNELS, 2: parallel serial data lines, ≥1
- clk  in  1  main clock; one clock domain
- rst_n  in  1  reset, asynchronous, active-low
- data  in  CHANNELS*DATA_BITS  frame; channel c = data[c*DATA_BITS +: DATA_BITS]
- dir  in  1  per-frame order: 0 LSB first, 1 MSB first; sampled with data
- in_valid  in  1  frame offered
- in_ready  out  1  holding buffer empty; transfer on in_valid && in_ready at rising clk
- busy  out  1  high while state ≠ IDLE or holding buffer full
- finish  out  1  one-cycle pulse per completed frame
- s_clk  out  1  serial clock; data sampled externally on rising edge
- s_clr  out  1  active-high clear, one half-period before each frame
- s_lat  out  1  active-high latch/strobe, one half-period after the last bit
- s_dat  out  CHANNELS  serial data, one line per channel

## Operation
- HALF = ceil(P_CLK_FREQ / (2*S_CLK_FREQ)), minimum 1. The s_clk period is 2*HALF cycles and never exceeds S_CLK_FREQ. Defaults give HALF=3 (16.7 MHz).
- Holding buffer: one frame plus its dir bit. in_ready = !buffer_full. The shifter loads from the buffer when it enters CLEAR, which empties the buffer.
- States:
  - IDLE: s_clk=0, s_clr=0, s_lat=0. Moves to CLEAR when the buffer is full.
  - CLEAR: s_clr=1 for HALF cycles, then SHIFT_LO with bit index 0.
  - SHIFT_LO: s_clk=0. s_dat presents the current bit for every channel. Lasts HALF cycles, then SHIFT_HI.
  - SHIFT_HI: s_clk=1, s_dat held. Lasts HALF cycles. Then SHIFT_LO with bit index +1, or LATCH after bit DATA_BITS-1.
  - LATCH: s_lat=1, s_dat held, HALF cycles, then DONE.
  - DONE: one cycle, finish=1. Goes to CLEAR if the buffer is full, else IDLE.
- Bit order: dir=1 sends bit DATA_BITS-1 first; dir=0 sends bit 0 first. dir is fixed for the whole frame.
- A half-period counter (0..HALF-1) wraps on each phase change. The bit counter is width clog2(DATA_BITS+1).
- Simultaneous events:
  - A transfer in the same cycle the shifter loads is allowed. The buffer stays full with the new frame.
  - In_valid during DONE with an empty buffer is accepted. CLEAR then follows DONE directly.
- Reset (at any time, including mid-frame):
  - All outputs go to 0 immediately except in_ready, which is 1 after reset.
  - The buffer and shifter are discarded and no finish is produced.
  - Operation resumes in IDLE on the first clk after rst_n rises.

## Timing
- Transfer at edge 0 → CLEAR from cycle 1.
- Frame length F = HALF + 2*HALF*DATA_BITS + HALF cycles, followed by one DONE cycle. Defaults: F=198, finish at cycle 199.
- Back-to-back frames: the next CLEAR starts the cycle after DONE. Period is F+1 cycles.
- All outputs are registered; no combinational path from inputs to serial outputs. in_ready depends only on internal state.
- s_dat changes only on entry to SHIFT_LO, which gives HALF cycles of setup and HALF cycles of hold around the rising s_clk.

## Structure
- Package p2s_pkg holds:
  - the state enum (IDLE, CLEAR, SHIFT_LO, SHIFT_HI, LATCH, DONE);
  - a function computing HALF from the frequencies;
  - a clog2 helper.
- Sub-module p2s_clk_div: half-period counter with a start/clear input and a one-cycle phase_tick output. The FSM, buffer and shifters stay in the top module. Per-channel shift registers are built with a generate loop.

## Test plan
- Defaults, one frame, data={32'hA5A5_0001, 32'h8000_00FF}, dir=1:
  - s_dat[1] bits sampled at rising s_clk read 0xA5A50001 MSB first; s_dat[0] reads 0x800000FF.
  - s_clr high cycles 1–3, s_lat high for 3 cycles, finish at cycle 199.
- Same data, dir=0: sampled streams equal the bit-reversed words. Exactly 32 rising s_clk edges per frame.
- Three frames offered with in_valid held high:
  - in_ready drops after the 2nd transfer and rises when frame 2 loads.
  - finish pulses at cycles 199, 398, 597; busy stays high throughout.
- P_CLK_FREQ=50, S_CLK_FREQ=25, DATA_BITS=4, CHANNELS=1:
  - HALF=1, frame length 10, s_clk toggles every cycle.
  - 4'b1011 with dir=1 yields 1,0,1,1.
- rst_n low at cycle 50 mid-shift:
  - s_clk, s_dat, s_lat, busy go 0 immediately; no finish appears.
  - The buffered frame is lost; a new frame after release completes normally.

Source files
------------

// File: rtl/p2s_pkg.sv
// Shared types and elaboration-time helpers for the multi-channel parallel-to-serial converter.
package p2s_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CLEAR    = 3'd1,
        ST_SHIFT_LO = 3'd2,
        ST_SHIFT_HI = 3'd3,
        ST_LATCH    = 3'd4,
        ST_DONE     = 3'd5
    } p2s_state_e;

    function automatic int unsigned p2s_clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(value)) r++;
        return r;
    endfunction

    // Half-period of the serial clock in main-clock cycles, rounded up so s_clk never exceeds its limit.
    function automatic int unsigned p2s_half(input int unsigned p_mhz, input int unsigned s_mhz);
        int unsigned h;
        h = (p_mhz + 2 * s_mhz - 1) / (2 * s_mhz);
        return (h < 1) ? 1 : h;
    endfunction

endpackage

// File: rtl/parallel2serial_multi_if.sv
// Frame input handshake: parallel frame, bit-order flag and valid/ready.
interface parallel2serial_multi_if #(
    parameter int unsigned CHANNELS  = 2,
    parameter int unsigned DATA_BITS = 32
);
    logic [CHANNELS*DATA_BITS-1:0] data;
    logic                          dir;
    logic                          in_valid;
    logic                          in_ready;

    modport master (output data, output dir, output in_valid, input in_ready);
    modport slave  (input data, input dir, input in_valid, output in_ready);
endinterface

// File: rtl/p2s_clk_div.sv
// Half-period counter for the serial clock; o_phase_tick is high in the last cycle of each phase.
module p2s_clk_div
    import p2s_pkg::*;
#(
    parameter int unsigned HALF = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    output logic o_phase_tick
);

    localparam int unsigned    CNT_W = (HALF > 1) ? p2s_clog2(HALF) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(HALF - 1);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             r_tick;

    // Wrap at the end of a phase; a clear restarts the phase from the next cycle.
    always_comb begin
        w_cnt_next = '0;
        if (!i_clr && (r_cnt != LAST)) w_cnt_next = r_cnt + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_tick <= (LAST == '0);
        end else begin
            r_cnt  <= w_cnt_next;
            r_tick <= (w_cnt_next == LAST);
        end
    end

    assign o_phase_tick = r_tick;

endmodule

// File: rtl/parallel2serial_multi.sv
// Double-buffered multi-channel parallel-to-serial converter for 74HC595-style chains.
module parallel2serial_multi
    import p2s_pkg::*;
#(
    parameter int unsigned P_CLK_FREQ = 100,
    parameter int unsigned S_CLK_FREQ = 20,
    parameter int unsigned DATA_BITS  = 32,
    parameter int unsigned CHANNELS   = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    parallel2serial_multi_if.slave bus,
    output logic                busy,
    output logic                finish,
    output logic                s_clk,
    output logic                s_clr,
    output logic                s_lat,
    output logic [CHANNELS-1:0] s_dat
);

    localparam int unsigned HALF    = p2s_half(P_CLK_FREQ, S_CLK_FREQ);
    localparam int unsigned BIT_W   = p2s_clog2(DATA_BITS + 1);
    localparam int unsigned FRAME_W = CHANNELS * DATA_BITS;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);

    p2s_state_e         r_state;
    p2s_state_e         w_state_next;
    logic               w_tick;
    logic               w_state_chg;
    logic               w_xfer;
    logic               w_load;
    logic               w_shift;

    logic               r_buf_full;
    logic               w_buf_full_nx;
    logic [FRAME_W-1:0] r_buf_data;
    logic               r_buf_dir;
    logic [FRAME_W-1:0] w_src_data;
    logic               w_src_dir;
    logic               r_dir;
    logic [BIT_W-1:0]   r_bit;

    logic r_in_ready, r_busy, r_finish, r_s_clk, r_s_clr, r_s_lat;
    logic w_in_ready_nx, w_busy_nx, w_finish_nx, w_s_clk_nx, w_s_clr_nx, w_s_lat_nx;

    p2s_clk_div #(.HALF(HALF)) u_clk_div (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_clr        (w_state_chg),
        .o_phase_tick (w_tick)
    );

    assign w_xfer      = bus.in_valid && r_in_ready;
    assign w_state_chg = (w_state_next != r_state);
    assign w_load      = w_state_chg && (w_state_next == ST_CLEAR);
    assign w_shift     = w_state_chg && (w_state_next == ST_SHIFT_LO);
    // With an empty buffer the shifter loads straight from the bus (frame accepted during DONE).
    assign w_src_data  = r_buf_full ? r_buf_data : bus.data;
    assign w_src_dir   = r_buf_full ? r_buf_dir  : bus.dir;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:     if (r_buf_full) w_state_next = ST_CLEAR;
            ST_CLEAR:    if (w_tick) w_state_next = ST_SHIFT_LO;
            ST_SHIFT_LO: if (w_tick) w_state_next = ST_SHIFT_HI;
            ST_SHIFT_HI: if (w_tick) w_state_next = (r_bit == LAST_BIT) ? ST_LATCH : ST_SHIFT_LO;
            ST_LATCH:    if (w_tick) w_state_next = ST_DONE;
            ST_DONE:     w_state_next = (r_buf_full || w_xfer) ? ST_CLEAR : ST_IDLE;
            default:     w_state_next = ST_IDLE;
        endcase
    end

    // Output values for the coming cycle, decoded from the next state so outputs stay registered.
    always_comb begin
        w_buf_full_nx = r_buf_full;
        if (w_load)      w_buf_full_nx = r_buf_full && w_xfer;
        else if (w_xfer) w_buf_full_nx = 1'b1;
        w_s_clk_nx    = (w_state_next == ST_SHIFT_HI);
        w_s_clr_nx    = (w_state_next == ST_CLEAR);
        w_s_lat_nx    = (w_state_next == ST_LATCH);
        w_finish_nx   = (w_state_next == ST_DONE);
        w_busy_nx     = (w_state_next != ST_IDLE) || w_buf_full_nx;
        w_in_ready_nx = !w_buf_full_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_ready <= 1'b1;
            r_busy     <= 1'b0;
            r_finish   <= 1'b0;
            r_s_clk    <= 1'b0;
            r_s_clr    <= 1'b0;
            r_s_lat    <= 1'b0;
        end else begin
            r_in_ready <= w_in_ready_nx;
            r_busy     <= w_busy_nx;
            r_finish   <= w_finish_nx;
            r_s_clk    <= w_s_clk_nx;
            r_s_clr    <= w_s_clr_nx;
            r_s_lat    <= w_s_lat_nx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_buf_full <= 1'b0;
            r_buf_data <= '0;
            r_buf_dir  <= 1'b0;
            r_dir      <= 1'b0;
            r_bit      <= '0;
        end else begin
            r_buf_full <= w_buf_full_nx;
            if (w_xfer) begin
                r_buf_data <= bus.data;
                r_buf_dir  <= bus.dir;
            end
            if (w_load) begin
                r_dir <= w_src_dir;
                r_bit <= '0;
            end else if (w_shift && (r_state == ST_SHIFT_HI)) begin
                r_bit <= r_bit + BIT_W'(1);
            end
        end
    end

    // One shift register per channel; the next bit is presented only on entry to SHIFT_LO.
    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [DATA_BITS-1:0] r_sh;
        logic                 r_out;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_sh  <= '0;
                r_out <= 1'b0;
            end else if (w_load) begin
                r_sh <= w_src_data[c*DATA_BITS +: DATA_BITS];
            end else if (w_shift) begin
                r_out <= r_dir ? r_sh[DATA_BITS-1] : r_sh[0];
                r_sh  <= r_dir ? (r_sh << 1) : (r_sh >> 1);
            end
        end

        assign s_dat[c] = r_out;
    end

    assign bus.in_ready = r_in_ready;
    assign busy         = r_busy;
    assign finish       = r_finish;
    assign s_clk        = r_s_clk;
    assign s_clr        = r_s_clr;
    assign s_lat        = r_s_lat;

endmodule

// File: tb/tb_parallel2serial_multi.sv
// Scoreboard bench: default 2x32-bit instance plus a HALF=1, 1x4-bit instance.
module tb_parallel2serial_multi;

    localparam int unsigned DB_A = 32;
    localparam int unsigned CH_A = 2;
    localparam int unsigned DB_B = 4;
    localparam int unsigned CH_B = 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    parallel2serial_multi_if #(.CHANNELS(CH_A), .DATA_BITS(DB_A)) ifa ();
    parallel2serial_multi_if #(.CHANNELS(CH_B), .DATA_BITS(DB_B)) ifb ();

    logic a_busy, a_finish, a_sclk, a_sclr, a_slat;
    logic [CH_A-1:0] a_sdat;
    logic b_busy, b_finish, b_sclk, b_sclr, b_slat;
    logic [CH_B-1:0] b_sdat;

    parallel2serial_multi #(.P_CLK_FREQ(100), .S_CLK_FREQ(20), .DATA_BITS(DB_A), .CHANNELS(CH_A)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .bus(ifa), .busy(a_busy), .finish(a_finish),
        .s_clk(a_sclk), .s_clr(a_sclr), .s_lat(a_slat), .s_dat(a_sdat));

    parallel2serial_multi #(.P_CLK_FREQ(50), .S_CLK_FREQ(25), .DATA_BITS(DB_B), .CHANNELS(CH_B)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .bus(ifb), .busy(b_busy), .finish(b_finish),
        .s_clk(b_sclk), .s_clr(b_sclr), .s_lat(b_slat), .s_dat(b_sdat));

    typedef struct { int clr_cyc; int fin_cyc; logic [31:0] w1; logic [31:0] w0; } exp_a_t;
    typedef struct { int fin_cyc; logic [3:0] w; } exp_b_t;
    exp_a_t qa[$];
    exp_b_t qb[$];
    int last_fin_a = -1000;
    int busy_lo = -1, busy_hi = -2, busy_low_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Monitor for the default instance: assembles bits at rising s_clk, checks frame at finish.
    logic        pa_sclk, pa_sclr, pa_slat;
    int          a_clr_len, a_lat_len, a_rises, a_clr_start;
    logic [31:0] a_acc1, a_acc0;
    always @(negedge clk) begin
        exp_a_t e;
        if (!rst_n) begin
            pa_sclk = 0; pa_sclr = 0; pa_slat = 0;
            a_clr_len = 0; a_lat_len = 0; a_rises = 0; a_clr_start = -1;
            a_acc1 = '0; a_acc0 = '0;
        end else begin
            if (a_sclk && !pa_sclk) begin
                a_acc1 = {a_acc1[30:0], a_sdat[1]};
                a_acc0 = {a_acc0[30:0], a_sdat[0]};
                a_rises++;
            end
            if (a_sclr) begin
                if (!pa_sclr) a_clr_start = cyc;
                a_clr_len++;
            end else if (pa_sclr) begin
                check("a_clr_len", 64'(a_clr_len), 64'd3);
                a_clr_len = 0;
            end
            if (a_slat) a_lat_len++;
            else if (pa_slat) begin
                check("a_lat_len", 64'(a_lat_len), 64'd3);
                a_lat_len = 0;
            end
            if (busy_lo <= cyc && cyc <= busy_hi && !a_busy) busy_low_cnt++;
            if (a_finish) begin
                if (qa.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL a_unexpected_finish @cyc %0d: got finish expected none", cyc);
                end else begin
                    e = qa.pop_front();
                    check("a_finish_cyc", 64'(cyc), 64'(e.fin_cyc));
                    check("a_clr_start", 64'(a_clr_start), 64'(e.clr_cyc));
                    check("a_word_ch1", 64'(a_acc1), 64'(e.w1));
                    check("a_word_ch0", 64'(a_acc0), 64'(e.w0));
                    check("a_rises", 64'(a_rises), 64'd32);
                end
                a_rises = 0; a_acc1 = '0; a_acc0 = '0;
            end
            pa_sclk = a_sclk; pa_sclr = a_sclr; pa_slat = a_slat;
        end
    end

    // Monitor for the HALF=1 instance.
    logic       pb_sclk;
    int         b_rises;
    logic [3:0] b_acc;
    always @(negedge clk) begin
        exp_b_t e;
        if (!rst_n) begin
            pb_sclk = 0; b_rises = 0; b_acc = '0;
        end else begin
            if (b_sclk && !pb_sclk) begin
                b_acc = {b_acc[2:0], b_sdat[0]};
                b_rises++;
            end
            if (b_finish) begin
                if (qb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL b_unexpected_finish @cyc %0d: got finish expected none", cyc);
                end else begin
                    e = qb.pop_front();
                    check("b_finish_cyc", 64'(cyc), 64'(e.fin_cyc));
                    check("b_word", 64'(b_acc), 64'(e.w));
                    check("b_rises", 64'(b_rises), 64'd4);
                end
                b_rises = 0; b_acc = '0;
            end
            pb_sclk = b_sclk;
        end
    end

    // Offer one frame; t is the transfer edge. Expected CLEAR start follows the double-buffer rules.
    task automatic send_a(input logic [63:0] d, input logic dr, input logic [31:0] e1, input logic [31:0] e0,
                          output int t);
        exp_a_t e;
        int     ld;
        bit     ok;
        ifa.data = d; ifa.dir = dr; ifa.in_valid = 1'b1; ok = 0; t = -1;
        for (int k = 0; k < 1000; k++) begin
            if (ifa.in_ready) begin ok = 1; break; end
            @(negedge clk);
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL a_handshake_timeout @cyc %0d: got in_ready=0 expected 1", cyc);
            ifa.in_valid = 1'b0;
            return;
        end
        t = cyc + 1;
        if (t <= last_fin_a)          ld = last_fin_a + 1;
        else if (t == last_fin_a + 1) ld = t;
        else                          ld = t + 1;
        e.clr_cyc = ld; e.fin_cyc = ld + 198; e.w1 = e1; e.w0 = e0;
        qa.push_back(e);
        last_fin_a = e.fin_cyc;
        @(posedge clk); #1;
        ifa.in_valid = 1'b0;
    endtask

    task automatic send_b(input logic [3:0] d, input logic dr, input logic [3:0] ew);
        exp_b_t e;
        bit     ok;
        ifb.data = d; ifb.dir = dr; ifb.in_valid = 1'b1; ok = 0;
        for (int k = 0; k < 100; k++) begin
            if (ifb.in_ready) begin ok = 1; break; end
            @(negedge clk);
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL b_handshake_timeout @cyc %0d: got in_ready=0 expected 1", cyc);
            ifb.in_valid = 1'b0;
            return;
        end
        e.fin_cyc = cyc + 1 + 11; e.w = ew;
        qb.push_back(e);
        @(posedge clk); #1;
        ifb.in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int k = 0; k < 2000; k++) begin
            if (qa.size() == 0 && qb.size() == 0) break;
            @(negedge clk);
        end
        check(name, 64'(qa.size() + qb.size()), 64'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_a_outs"}, {58'd0, a_busy, a_finish, a_sclk, a_sclr, a_slat, ifa.in_ready}, 64'd1);
        check({tag, "_a_sdat"}, 64'(a_sdat), 64'd0);
        check({tag, "_b_outs"}, {58'd0, b_busy, b_finish, b_sclk, b_sclr, b_slat, ifb.in_ready}, 64'd1);
    endtask

    initial begin
        int t1, t2, t3, tp;
        ifa.data = '0; ifa.dir = 1'b0; ifa.in_valid = 1'b0;
        ifb.data = '0; ifb.dir = 1'b0; ifb.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single frames, MSB first then LSB first (streams read back bit-reversed).
        send_a({32'hA5A5_0001, 32'h8000_00FF}, 1'b1, 32'hA5A5_0001, 32'h8000_00FF, t1);
        drain("a_msb_frame_done");
        repeat (5) @(negedge clk);
        send_a({32'hA5A5_0001, 32'h8000_00FF}, 1'b0, 32'h8000_A5A5, 32'hFF00_0001, t1);
        drain("a_lsb_frame_done");
        repeat (5) @(negedge clk);

        // Back-to-back frames with in_valid held.
        send_a({32'h0F0F_0F0F, 32'h1234_5678}, 1'b1, 32'h0F0F_0F0F, 32'h1234_5678, t1);
        busy_lo = t1; busy_hi = t1 + 597;
        send_a({32'hCAFE_F00D, 32'h0000_0000}, 1'b1, 32'hCAFE_F00D, 32'h0000_0000, t2);
        send_a({32'hFFFF_FFFF, 32'h8765_4321}, 1'b1, 32'hFFFF_FFFF, 32'h8765_4321, t3);
        check("b2b_second_xfer", 64'(t2 - t1), 64'd2);
        check("b2b_third_xfer", 64'(t3 - t1), 64'd201);
        drain("b2b_frames_done");
        check("b2b_busy_low_cycles", 64'(busy_low_cnt), 64'd0);
        busy_lo = -1; busy_hi = -2;
        repeat (5) @(negedge clk);

        // Frame offered during DONE with an empty buffer goes straight to CLEAR.
        send_a({32'h0000_0010, 32'h0000_0020}, 1'b1, 32'h0000_0010, 32'h0000_0020, tp);
        while (cyc < last_fin_a) @(negedge clk);
        send_a({32'h0000_0001, 32'h0000_0003}, 1'b0, 32'h8000_0000, 32'hC000_0000, t1);
        check("done_accept_xfer", 64'(t1 - tp), 64'd200);
        drain("done_accept_done");

        // HALF=1 instance, both bit orders.
        send_b(4'b1011, 1'b1, 4'b1011);
        drain("b_msb_done");
        send_b(4'b1011, 1'b0, 4'b1101);
        drain("b_lsb_done");
        repeat (3) @(negedge clk);

        // Reset mid-shift with a second frame buffered; both are discarded.
        send_a({32'h1111_2222, 32'h3333_4444}, 1'b1, 32'h1111_2222, 32'h3333_4444, t1);
        send_a({32'h5555_6666, 32'h7777_8888}, 1'b1, 32'h5555_6666, 32'h7777_8888, t2);
        while (cyc < t1 + 50) @(negedge clk);
        rst_n = 1'b0;
        qa.delete();
        last_fin_a = -1000;
        #1;
        check_reset_outputs("midrst");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("midrst_buffer_lost", {62'd0, a_busy, ifa.in_ready}, 64'd1);
        send_a({32'h1234_5678, 32'hDEAD_BEEF}, 1'b1, 32'h1234_5678, 32'hDEAD_BEEF, t3);
        drain("midrst_new_frame_done");
        repeat (5) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
